// File: rtl/dump_event_gen.sv
// Per-channel dump strobe generator: each channel emits a one-cycle dump
// after every N code epochs. N, the SYNC mask and the dump counter sit on a simple register bus.
module dump_event_gen #(
    parameter int NUM_CH = 12
) (
    input  logic              clk,
    input  logic              hw_rstn,
    input  logic              chip_select,
    input  logic              write,
    input  logic              read,
    input  logic [7:0]        address,
    input  logic [31:0]       write_data,
    output logic [31:0]       read_data,
    input  logic [NUM_CH-1:0] ch_epoch,
    output logic [NUM_CH-1:0] ch_dump
);

    localparam logic [7:0] ADDR_N_BASE = 8'hC0;
    localparam logic [7:0] ADDR_SYNC   = 8'hCD;
    localparam logic [7:0] ADDR_DCOUNT = 8'hCE;
    localparam logic [7:0] ADDR_SRST   = 8'hF0;

    logic              w_wr;
    logic              w_srst;
    logic              w_sync_sel;
    logic [NUM_CH-1:0] w_dump;
    logic [4:0]        w_n_all [NUM_CH];
    logic [31:0]       w_rd_mux;
    logic [15:0]       r_dump_count;
    logic [31:0]       r_read_data;
    logic              w_unused;

    // Reads have no side effects, so the read strobe is not needed by the logic.
    assign w_unused   = read ^ (^write_data[31:NUM_CH]);

    assign w_wr       = chip_select & write;
    assign w_srst     = w_wr && (address == ADDR_SRST);
    assign w_sync_sel = w_wr && (address == ADDR_SYNC);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic       w_n_wr;
            logic [4:0] w_n_eff;
            logic       w_hit;
            logic       w_sync;
            logic [4:0] r_n;
            logic [4:0] r_cnt;
            logic       r_dump;

            assign w_n_wr  = w_wr && (address == 8'(ADDR_N_BASE + gi));
            // A new N takes effect in its own write cycle.
            assign w_n_eff = w_n_wr ? write_data[4:0] : r_n;
            // Compare with >= so a reduced N dumps on the next epoch instead of waiting for wrap.
            assign w_hit   = r_cnt >= (w_n_eff - 5'd1);
            assign w_sync  = w_sync_sel && write_data[gi];

            always_ff @(posedge clk or negedge hw_rstn) begin
                if (!hw_rstn) begin
                    r_n    <= 5'd0;
                    r_cnt  <= 5'd0;
                    r_dump <= 1'b0;
                end else if (w_srst) begin
                    r_n    <= 5'd0;
                    r_cnt  <= 5'd0;
                    r_dump <= 1'b0;
                end else begin
                    r_n    <= w_n_eff;
                    r_dump <= 1'b0;
                    if (w_n_eff == 5'd0 || w_sync) begin
                        r_cnt <= 5'd0;
                    end else if (ch_epoch[gi]) begin
                        if (w_hit) begin
                            r_cnt  <= 5'd0;
                            r_dump <= 1'b1;
                        end else begin
                            r_cnt  <= r_cnt + 5'd1;
                        end
                    end
                end
            end

            assign w_dump[gi]  = r_dump;
            assign w_n_all[gi] = r_n;
        end
    endgenerate

    always_comb begin
        w_rd_mux = 32'h0;
        if (address == ADDR_DCOUNT) begin
            w_rd_mux = {16'h0, r_dump_count};
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (address == 8'(ADDR_N_BASE + i)) begin
                w_rd_mux = {27'h0, w_n_all[i]};
            end
        end
    end

    always_ff @(posedge clk or negedge hw_rstn) begin
        if (!hw_rstn) begin
            r_dump_count <= 16'h0;
            r_read_data  <= 32'h0;
        end else begin
            if (w_srst) begin
                r_dump_count <= 16'h0;
            end else if (|w_dump) begin
                r_dump_count <= r_dump_count + 16'h1;
            end
            r_read_data <= w_rd_mux;
        end
    end

    assign ch_dump   = w_dump;
    assign read_data = r_read_data;

endmodule

// File: doc/dump_event_gen.md
DUMP_EVENT_GEN -- requirements
Module: dump_event_gen

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all logic on rising edge.
REQ-002 SHALL have port: hw_rstn  input  1  reset; one clock, reset is asynchronous and active-low.
REQ-003 SHALL have port: chip_select  input  1  bus select, qualifies read/write.
REQ-004 SHALL have port: write  input  1  bus write strobe.
REQ-005 SHALL have port: read  input  1  bus read strobe.
REQ-006 SHALL have port: address  input  8  register address.
REQ-007 SHALL have port: write_data  input  32  bus write data.
REQ-008 SHALL have port: read_data  output  32  registered bus read data.
REQ-009 SHALL have port: ch_epoch  input  12  per-channel code-epoch strobe from tracking channels, bit n = channel n, one cycle wide.
REQ-010 SHALL have port: ch_dump  output  12  per-channel accumulation-dump strobe to the dump status block, bit n = channel n.
REQ-011 SHALL have parameter: NUM_CH, default 12, number of channels; all per-channel logic generated per channel.

Function
REQ-012 SHALL hold per channel a 5-bit DUMP_EPOCHS register N at address 8'hC0+n (n=0..11), written from write_data[4:0] when chip_select & write.
REQ-013 SHALL treat N=0 as channel disabled: no ch_dump, epoch counter held at 0.
REQ-014 SHALL hold per channel a 5-bit epoch counter cnt, incremented on each ch_epoch[n] while N!=0.
REQ-015 SHALL, on ch_epoch[n] with cnt >= N-1, set cnt to 0 and assert ch_dump[n] high for exactly one clock in the cycle after the epoch (registered, latency 1).
REQ-016 SHALL assert no ch_dump[n] on any cycle without a preceding ch_epoch[n]; back-to-back epochs with N=1 SHALL give back-to-back dumps.
REQ-017 SHALL apply a new N from the write cycle onward; a reduced N with cnt >= new N-1 SHALL dump on the next epoch (compare is >=, never waits for 5-bit wrap).
REQ-018 SHALL clear cnt to 0 in the cycle a write of N=0 occurs.
REQ-019 SHALL provide SYNC at 8'hCD (write-only): write_data[11:0] mask; each set bit clears that channel's cnt to 0.
REQ-020 SHALL give SYNC priority over a simultaneous ch_epoch[n]: cnt becomes 0 and no ch_dump[n] is produced for that epoch.
REQ-021 SHALL provide DUMP_COUNT at 8'hCE (read-only): 16-bit free-running count of cycles with any ch_dump bit set, wrapping 16'hFFFF->0; writes ignored.
REQ-022 SHALL decode software reset on a write to 8'hF0: synchronously clear all N, cnt, ch_dump and DUMP_COUNT on the next edge.
REQ-023 SHALL update read_data every clock from address: 8'hC0+n -> {27'h0,N[n]}, 8'hCE -> {16'h0,DUMP_COUNT}, all other addresses (including 8'hCD, 8'hF0) -> 32'h0.
REQ-024 SHALL have reads without side effects.
REQ-025 SHALL ignore writes to unmapped addresses and any write/read without chip_select.

Reset
REQ-026 SHALL, while hw_rstn low, asynchronously force all N=0, all cnt=0, ch_dump=12'h000, DUMP_COUNT=0, read_data=32'h0.
REQ-027 SHALL, after hw_rstn rises, ignore epochs until a channel's N is written non-zero; reset mid-period discards partial counts.

Verification
REQ-028 SHALL verify: reset, write N[0]=20 at 8'hC0, 45 ch_epoch[0] pulses 10 cycles apart -> ch_dump[0] one cycle after epochs 20 and 40 only; DUMP_COUNT reads 2.
REQ-029 SHALL verify: N[3]=1, ch_epoch[3] high 4 consecutive cycles -> ch_dump[3] high 4 consecutive cycles, each delayed 1 clock.
REQ-030 SHALL verify: N[5]=10, 7 epochs, then write N[5]=4 -> dump on the very next epoch, then every 4th.
REQ-031 SHALL verify: N[2]=2, epoch, then SYNC 12'h004 coincident with next epoch -> no dump; dump after 2 further epochs.
REQ-032 SHALL verify: all 12 channels N=1, common epoch -> ch_dump=12'hFFF one cycle, DUMP_COUNT increments by 1; then write 8'hF0 -> all reads of 8'hC0..CB and 8'hCE return 0, further epochs give no dumps.
REQ-033 SHALL verify: hw_rstn asserted mid-period (N[0]=20, cnt=15) -> ch_dump and read_data zero immediately without a clock edge; after release, N[0] reads 0.
